// File: rtl/board_move_ctrl_if.sv
// board_move_ctrl_if: handshake and data bundle for the 2048 board controller.
//   master : drives Start, btnU/btnD/btnL/btnR, rand_in; observes board, score,
//            busy, won, lost
//   slave  : the controller side of the same signals
interface board_move_ctrl_if #(
   parameter int CELL_W  = 4,
   parameter int SCORE_W = 20
);
   logic                    Start;
   logic                    btnU;
   logic                    btnD;
   logic                    btnL;
   logic                    btnR;
   logic [3:0]              rand_in;
   logic [16*CELL_W-1:0]    board;
   logic [SCORE_W-1:0]      score;
   logic                    busy;
   logic                    won;
   logic                    lost;

   modport master (
      output Start, btnU, btnD, btnL, btnR, rand_in,
      input  board, score, busy, won, lost
   );

   modport slave (
      input  Start, btnU, btnD, btnL, btnR, rand_in,
      output board, score, busy, won, lost
   );
endinterface

// File: rtl/board_move_ctrl.sv
// board_move_ctrl: sequencing controller for the 2048 tile board.
//   ClkPort : system clock, rising edge
//   Reset   : synchronous active-high reset
//   bus     : slave side of board_move_ctrl_if
//             in  Start, btnU/D/L/R (one-shot pulses), rand_in (spawn start index)
//             out board (cell i at [CELL_W*i +: CELL_W]), score, busy, won, lost
// A move runs one line per cycle (4 cycles), then a spawn and a win/loss check
// when the board changed.
module board_move_ctrl #(
   parameter int CELL_W  = 4,
   parameter int WIN_EXP = 11,
   parameter int SCORE_W = 20
) (
   input logic              ClkPort,
   input logic              Reset,
   board_move_ctrl_if.slave bus
);
   typedef enum logic [2:0] {
      S_IDLE, S_INIT_SPAWN, S_READY, S_MOVE, S_SPAWN, S_CHECK, S_OVER
   } state_t;
   typedef enum logic [1:0] {DIR_U, DIR_D, DIR_L, DIR_R} dir_t;
   typedef logic [CELL_W-1:0] cell_t;

   state_t              state, state_n;
   dir_t                dir, dir_n;
   logic [1:0]          line_idx, line_idx_n;
   logic                changed, changed_n;
   logic                init_cnt, init_cnt_n;
   cell_t               cells [16];
   cell_t               cells_n [16];
   logic [SCORE_W-1:0]  score, score_n;
   logic                won, won_n, lost, lost_n;

   // Slot 0 is the destination end of the line; cell index = {row, col}.
   function automatic logic [3:0] cell_index(input dir_t d, input logic [1:0] line,
                                             input logic [1:0] slot);
      case (d)
         DIR_L:   return {line, slot};
         DIR_R:   return {line, ~slot};
         DIR_U:   return {slot, line};
         default: return {~slot, line};
      endcase
   endfunction

   // Adds 2^e to the score, saturating at all-ones.
   function automatic logic [SCORE_W-1:0] sat_add(input logic [SCORE_W-1:0] acc,
                                                  input cell_t e);
      logic [SCORE_W-1:0] pow;
      logic [SCORE_W:0]   sum;
      if (int'(e) >= SCORE_W) pow = '1;
      else                    pow = SCORE_W'(1) << e;
      sum = {1'b0, acc} + {1'b0, pow};
      return sum[SCORE_W] ? '1 : sum[SCORE_W-1:0];
   endfunction

   // Line datapath: compress, then single-pass merge scan from slot 0.
   cell_t              line_in [4];
   cell_t              comp [5];
   cell_t              line_out [4];
   cell_t              merged;
   logic [SCORE_W-1:0] line_score;
   logic               line_chg;
   logic [2:0]         k;
   logic               skip;

   always_comb begin
      for (int unsigned s = 0; s < 4; s++)
         line_in[s] = cells[cell_index(dir, line_idx, 2'(s))];
      // comp[4] stays empty so the pair test at slot 3 never matches.
      for (int unsigned s = 0; s < 5; s++) comp[s] = '0;
      k = '0;
      for (int unsigned s = 0; s < 4; s++) begin
         if (line_in[s] != '0) begin
            comp[k[1:0]] = line_in[s];
            k = k + 3'd1;
         end
      end
      for (int unsigned s = 0; s < 4; s++) line_out[s] = '0;
      k          = '0;
      skip       = 1'b0;
      merged     = '0;
      line_score = score;
      for (int unsigned s = 0; s < 4; s++) begin
         if (skip) begin
            skip = 1'b0;
         end else if (comp[s] != '0) begin
            if (comp[s] == comp[s+1]) begin
               merged           = (comp[s] == '1) ? comp[s] : comp[s] + cell_t'(1);
               line_out[k[1:0]] = merged;
               line_score       = sat_add(line_score, merged);
               skip             = 1'b1;
            end else begin
               line_out[k[1:0]] = comp[s];
            end
            k = k + 3'd1;
         end
      end
      line_chg = 1'b0;
      for (int unsigned s = 0; s < 4; s++)
         if (line_out[s] != line_in[s]) line_chg = 1'b1;
   end

   // Spawn: first empty cell at or above rand_in, wrapping 15 -> 0.
   cell_t      spawn_cells [16];
   logic       found;
   logic [3:0] sidx;

   always_comb begin
      spawn_cells = cells;
      found       = 1'b0;
      sidx        = '0;
      for (int unsigned j = 0; j < 16; j++) begin
         sidx = bus.rand_in + 4'(j);
         if (!found && cells[sidx] == '0) begin
            spawn_cells[sidx] = cell_t'(1);
            found             = 1'b1;
         end
      end
   end

   // Win / loss evaluation over the current board.
   logic win_c, any_empty, any_pair, lost_c;

   always_comb begin
      win_c     = 1'b0;
      any_empty = 1'b0;
      any_pair  = 1'b0;
      for (int unsigned i = 0; i < 16; i++) begin
         if (cells[i] == '0)            any_empty = 1'b1;
         if (int'(cells[i]) >= WIN_EXP) win_c     = 1'b1;
      end
      for (int unsigned r = 0; r < 4; r++) begin
         for (int unsigned c = 0; c < 4; c++) begin
            if (c < 3 && cells[r*4+c] == cells[r*4+c+1])   any_pair = 1'b1;
            if (r < 3 && cells[r*4+c] == cells[(r+1)*4+c]) any_pair = 1'b1;
         end
      end
      lost_c = !any_empty && !any_pair;
   end

   always_comb begin
      state_n    = state;
      dir_n      = dir;
      line_idx_n = line_idx;
      changed_n  = changed;
      init_cnt_n = init_cnt;
      cells_n    = cells;
      score_n    = score;
      won_n      = won;
      lost_n     = lost;
      case (state)
         S_IDLE: begin
            init_cnt_n = 1'b0;
            if (bus.Start) state_n = S_INIT_SPAWN;
         end
         S_INIT_SPAWN: begin
            cells_n    = spawn_cells;
            init_cnt_n = 1'b1;
            if (init_cnt) state_n = S_READY;
         end
         S_READY: begin
            if (bus.btnU || bus.btnD || bus.btnL || bus.btnR) begin
               if      (bus.btnU) dir_n = DIR_U;
               else if (bus.btnD) dir_n = DIR_D;
               else if (bus.btnL) dir_n = DIR_L;
               else               dir_n = DIR_R;
               line_idx_n = '0;
               changed_n  = 1'b0;
               state_n    = S_MOVE;
            end
         end
         S_MOVE: begin
            for (int unsigned s = 0; s < 4; s++)
               cells_n[cell_index(dir, line_idx, 2'(s))] = line_out[s];
            score_n    = line_score;
            line_idx_n = line_idx + 2'd1;
            changed_n  = changed | line_chg;
            if (line_idx == 2'd3) state_n = (changed | line_chg) ? S_SPAWN : S_READY;
         end
         S_SPAWN: begin
            cells_n = spawn_cells;
            state_n = S_CHECK;
         end
         S_CHECK: begin
            won_n   = won | win_c;
            lost_n  = lost | lost_c;
            state_n = (win_c || lost_c) ? S_OVER : S_READY;
         end
         S_OVER:  state_n = S_OVER;
         default: state_n = S_IDLE;
      endcase
   end

   always_ff @(posedge ClkPort) begin
      if (Reset) begin
         state    <= S_IDLE;
         dir      <= DIR_U;
         line_idx <= '0;
         changed  <= 1'b0;
         init_cnt <= 1'b0;
         cells    <= '{default: '0};
         score    <= '0;
         won      <= 1'b0;
         lost     <= 1'b0;
      end else begin
         state    <= state_n;
         dir      <= dir_n;
         line_idx <= line_idx_n;
         changed  <= changed_n;
         init_cnt <= init_cnt_n;
         cells    <= cells_n;
         score    <= score_n;
         won      <= won_n;
         lost     <= lost_n;
      end
   end

   logic [16*CELL_W-1:0] board_flat;
   always_comb begin
      board_flat = '0;
      for (int unsigned i = 0; i < 16; i++) board_flat[CELL_W*i +: CELL_W] = cells[i];
   end

   assign bus.board = board_flat;
   assign bus.score = score;
   assign bus.busy  = (state == S_INIT_SPAWN) || (state == S_MOVE) ||
                      (state == S_SPAWN) || (state == S_CHECK);
   assign bus.won   = won;
   assign bus.lost  = lost;
endmodule

// File: tb/tb_board_move_ctrl.sv
// tb_board_move_ctrl: directed vector bench for board_move_ctrl. A second
// instance with WIN_EXP=2 shares the stimulus and exercises the win path.
module tb_board_move_ctrl;
   logic clk;
   logic rst;
   int   n_checks;
   int   n_fail;

   board_move_ctrl_if #(.CELL_W(4), .SCORE_W(20)) if0 ();
   board_move_ctrl_if #(.CELL_W(4), .SCORE_W(20)) if1 ();

   board_move_ctrl #(.CELL_W(4), .WIN_EXP(11), .SCORE_W(20)) dut (
      .ClkPort(clk), .Reset(rst), .bus(if0));
   board_move_ctrl #(.CELL_W(4), .WIN_EXP(2), .SCORE_W(20)) dut_w (
      .ClkPort(clk), .Reset(rst), .bus(if1));

   assign if1.Start   = if0.Start;
   assign if1.btnU    = if0.btnU;
   assign if1.btnD    = if0.btnD;
   assign if1.btnL    = if0.btnL;
   assign if1.btnR    = if0.btnR;
   assign if1.rand_in = if0.rand_in;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]  btn;       // {U, D, L, R}
      logic [3:0]  rnd;
      int          busy_cyc;
      logic [63:0] board;
      logic [19:0] score;
   } vec_t;

   vec_t vecs [7];

   function automatic logic [15:0] row(input logic [3:0] a, b, c, d);
      return {d, c, b, a};
   endfunction

   function automatic logic [63:0] mkb(input logic [15:0] r0, r1, r2, r3);
      return {r3, r2, r1, r0};
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Called at the negedge just after the accepting edge; counts busy cycles.
   task automatic run_busy(output int cnt);
      cnt = 0;
      while (if0.busy === 1'b1 && cnt < 30) begin
         cnt++;
         @(negedge clk);
      end
   endtask

   task automatic startup(input logic [3:0] rnd, input logic [63:0] exp_board);
      int cnt;
      @(negedge clk);
      if0.Start   = 1'b1;
      if0.rand_in = rnd;
      @(negedge clk);
      run_busy(cnt);
      if0.Start = 1'b0;
      check("start_busy_cycles", 64'(cnt), 64'd2);
      check("start_board", if0.board, exp_board);
      check("start_score", 64'(if0.score), 64'd0);
      check("start_busy", 64'(if0.busy), 64'd0);
   endtask

   initial begin
      int cnt;
      logic [63:0] snap;
      logic saw_busy;
      n_checks = 0;
      n_fail   = 0;
      rst = 1'b1;
      if0.Start = 1'b0;
      {if0.btnU, if0.btnD, if0.btnL, if0.btnR} = 4'b0000;
      if0.rand_in = 4'd0;

      vecs[0] = '{4'b0010, 4'd5,  6, mkb(16'h0, row(2,1,0,0), 16'h0, 16'h0), 20'd4};
      vecs[1] = '{4'b0010, 4'd5,  4, mkb(16'h0, row(2,1,0,0), 16'h0, 16'h0), 20'd4};
      vecs[2] = '{4'b1001, 4'd0,  6, mkb(row(2,1,1,0), 16'h0, 16'h0, 16'h0), 20'd4};
      vecs[3] = '{4'b0001, 4'd0,  6, mkb(row(1,0,2,2), 16'h0, 16'h0, 16'h0), 20'd8};
      vecs[4] = '{4'b0010, 4'd3,  6, mkb(row(1,3,0,1), 16'h0, 16'h0, 16'h0), 20'd16};
      vecs[5] = '{4'b0100, 4'd15, 6, mkb(row(1,0,0,0), 16'h0, 16'h0, row(1,3,0,1)), 20'd16};
      vecs[6] = '{4'b1000, 4'd15, 6, mkb(row(2,3,0,1), 16'h0, 16'h0, row(0,0,0,1)), 20'd20};

      repeat (3) @(negedge clk);
      check("rst_board", if0.board, 64'd0);
      check("rst_score", 64'(if0.score), 64'd0);
      check("rst_busy", 64'(if0.busy), 64'd0);
      check("rst_won", 64'(if0.won), 64'd0);
      check("rst_lost", 64'(if0.lost), 64'd0);
      rst = 1'b0;

      startup(4'd5, mkb(16'h0, row(0,1,1,0), 16'h0, 16'h0));

      for (int i = 0; i < 7; i++) begin
         @(negedge clk);
         if0.rand_in = vecs[i].rnd;
         {if0.btnU, if0.btnD, if0.btnL, if0.btnR} = vecs[i].btn;
         @(negedge clk);
         {if0.btnU, if0.btnD, if0.btnL, if0.btnR} = 4'b0000;
         run_busy(cnt);
         check($sformatf("v%0d_busy_cycles", i), 64'(cnt), 64'(vecs[i].busy_cyc));
         check($sformatf("v%0d_board", i), if0.board, vecs[i].board);
         check($sformatf("v%0d_score", i), 64'(if0.score), 64'(vecs[i].score));
         check($sformatf("v%0d_won", i), 64'(if0.won), 64'd0);
         check($sformatf("v%0d_lost", i), 64'(if0.lost), 64'd0);
      end

      // WIN_EXP=2 instance: won after the first left move, then frozen in OVER.
      check("win_won", 64'(if1.won), 64'd1);
      check("win_lost", 64'(if1.lost), 64'd0);
      check("win_busy", 64'(if1.busy), 64'd0);
      check("win_board_frozen", if1.board, mkb(16'h0, row(2,1,0,0), 16'h0, 16'h0));
      check("win_score_frozen", 64'(if1.score), 64'd4);

      // Buttons pulsed while busy are dropped.
      @(negedge clk);
      if0.rand_in = 4'd4;
      if0.btnL    = 1'b1;
      @(negedge clk);
      if0.btnL = 1'b0;
      if0.btnR = 1'b1;
      if0.btnD = 1'b1;
      @(negedge clk);
      if0.btnR = 1'b0;
      if0.btnD = 1'b0;
      run_busy(cnt);
      cnt = cnt + 1;
      check("mask_busy_cycles", 64'(cnt), 64'd6);
      snap = mkb(row(2,3,1,0), row(1,0,0,0), 16'h0, row(1,0,0,0));
      check("mask_board", if0.board, snap);
      saw_busy = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (if0.busy) saw_busy = 1'b1;
      end
      check("mask_no_second_move", 64'(saw_busy), 64'd0);
      check("mask_board_held", if0.board, snap);
      check("mask_score_held", 64'(if0.score), 64'd20);

      // Reset during the second MOVE cycle.
      if0.rand_in = 4'd0;
      if0.btnU    = 1'b1;
      @(negedge clk);
      if0.btnU = 1'b0;
      check("mid_busy_move1", 64'(if0.busy), 64'd1);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("mid_rst_board", if0.board, 64'd0);
      check("mid_rst_score", 64'(if0.score), 64'd0);
      check("mid_rst_busy", 64'(if0.busy), 64'd0);
      check("mid_rst_won_w", 64'(if1.won), 64'd0);
      check("mid_rst_board_w", if1.board, 64'd0);
      saw_busy = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (if0.busy || if0.board != 64'd0) saw_busy = 1'b1;
      end
      check("mid_stays_idle", 64'(saw_busy), 64'd0);

      startup(4'd9, mkb(16'h0, 16'h0, row(0,1,1,0), 16'h0));
      check("restart_board_w", if1.board, mkb(16'h0, 16'h0, row(0,1,1,0), 16'h0));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation time limit reached");
      $fatal(1);
   end
endmodule
